forward_detector: RTL

//  Upstream of stall_control. Tracks the destination registers of instructions in flight in the

---
 rtl/forward_detector_pkg.sv | 17 +
 rtl/forward_detector_dest_match.sv | 20 ++
 rtl/forward_detector.sv | 92 +++++++++
 3 files changed

// File: rtl/forward_detector_pkg.sv
// Shared bypass-select encodings and defaults for the forwarding detector
// and the operand-mux logic that consumes its selects.
package forward_detector_pkg;

    localparam int unsigned DEFAULT_REG_W        = 4;
    localparam int unsigned DEFAULT_LOAD_LATENCY = 1;

    localparam int unsigned FWD_SEL_NONE = 0;
    localparam int unsigned FWD_SEL_EXE  = 1;
    localparam int unsigned FWD_SEL_WRI0 = 2;

    // Slot index 0 is exe and slot index 1+i is wri[i]; the select code follows that order.
    function automatic int unsigned slot_sel(input int unsigned slot);
        return FWD_SEL_EXE + slot;
    endfunction

endpackage

// File: rtl/forward_detector_dest_match.sv
// Compares one in-flight destination slot against both decode source operands.
module dest_match
    import forward_detector_pkg::*;
#(
    parameter int unsigned REG_W = DEFAULT_REG_W
) (
    input  logic             slot_vld,
    input  logic [REG_W-1:0] slot_tag,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_vld,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_vld,
    output logic             match_a,
    output logic             match_b
);

    assign match_a = slot_vld && src_a_vld && (slot_tag == src_a);
    assign match_b = slot_vld && src_b_vld && (slot_tag == src_b);

endmodule

// File: rtl/forward_detector.sv
// Tracks destination tags in the exe and write-back slots and resolves, per decode
// source operand, which in-flight producer (youngest first) must be bypassed.
module forward_detector
    import forward_detector_pkg::*;
#(
    parameter  int unsigned LOAD_LATENCY = DEFAULT_LOAD_LATENCY,
    parameter  int unsigned REG_W        = DEFAULT_REG_W,
    localparam int unsigned SEL_W        = $clog2(LOAD_LATENCY + 3)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_W-1:0]      dec_src_a,
    input  logic                  dec_src_a_vld,
    input  logic [REG_W-1:0]      dec_src_b,
    input  logic                  dec_src_b_vld,
    input  logic [REG_W-1:0]      dec_dst,
    input  logic                  dec_dst_vld,
    input  logic                  stall_phase,
    input  logic                  flush,
    output logic                  forward_from_exe,
    output logic [LOAD_LATENCY:0] forward_from_wri,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b
);

    localparam int unsigned NUM_SLOTS = LOAD_LATENCY + 2;

    // Slot 0 = exe, slot 1+i = wri[i]; lower index is the younger producer.
    logic [NUM_SLOTS-1:0]            slot_vld;
    logic [NUM_SLOTS-1:0][REG_W-1:0] slot_tag;
    logic [NUM_SLOTS-1:0]            match_a;
    logic [NUM_SLOTS-1:0]            match_b;
    logic [NUM_SLOTS-1:0]            win_a;
    logic [NUM_SLOTS-1:0]            win_b;
    logic [NUM_SLOTS-1:0]            win_any;
    logic                            found_a;
    logic                            found_b;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_vld <= '0;
            slot_tag <= '0;
        end else begin
            // A stalled or flushed decode instruction enters exe as a bubble.
            slot_vld[0] <= dec_dst_vld && !stall_phase && !flush;
            slot_tag[0] <= dec_dst;
            for (int unsigned k = 1; k < NUM_SLOTS; k++) begin
                slot_vld[k] <= slot_vld[k-1];
                slot_tag[k] <= slot_tag[k-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
        dest_match #(.REG_W(REG_W)) u_dest_match (
            .slot_vld  (slot_vld[g]),
            .slot_tag  (slot_tag[g]),
            .src_a     (dec_src_a),
            .src_a_vld (dec_src_a_vld),
            .src_b     (dec_src_b),
            .src_b_vld (dec_src_b_vld),
            .match_a   (match_a[g]),
            .match_b   (match_b[g])
        );
    end

    always_comb begin
        win_a     = '0;
        win_b     = '0;
        found_a   = 1'b0;
        found_b   = 1'b0;
        fwd_sel_a = SEL_W'(FWD_SEL_NONE);
        fwd_sel_b = SEL_W'(FWD_SEL_NONE);
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (match_a[k] && !found_a) begin
                found_a   = 1'b1;
                win_a[k]  = 1'b1;
                fwd_sel_a = SEL_W'(slot_sel(k));
            end
            if (match_b[k] && !found_b) begin
                found_b   = 1'b1;
                win_b[k]  = 1'b1;
                fwd_sel_b = SEL_W'(slot_sel(k));
            end
        end
    end

    assign win_any          = win_a | win_b;
    assign forward_from_exe = win_any[0];
    assign forward_from_wri = win_any[NUM_SLOTS-1:1];

endmodule
